// File: rtl/mem_unit_param_if.sv
// rtl/mem_unit_param_if.sv - fetch, data and instruction-load signal bundle for mem_unit_param
interface mem_unit_param_if #(
  parameter int DATA_W   = 16,
  parameter int I_ADDR_W = 6,
  parameter int D_ADDR_W = 8
);
  logic [I_ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0]   ir;
  logic                i_valid;

  logic                d_req;
  logic                d_rw;
  logic [D_ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0]   dw_data;
  logic                d_ready;
  logic [DATA_W-1:0]   dr;
  logic                dr_valid;

  logic                ld_valid;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_last;
  logic                ld_ready;
  logic                init_done;

  modport master (
    output i_addr, d_req, d_rw, d_addr, dw_data, ld_valid, ld_data, ld_last,
    input  ir, i_valid, d_ready, dr, dr_valid, ld_ready, init_done
  );

  modport slave (
    input  i_addr, d_req, d_rw, d_addr, dw_data, ld_valid, ld_data, ld_last,
    output ir, i_valid, d_ready, dr, dr_valid, ld_ready, init_done
  );
endinterface

// File: rtl/mem_unit_param.sv
// rtl/mem_unit_param.sv - split instruction/data memory with clear, streamed load and run phases
module mem_unit_param #(
  parameter int              DATA_W     = 16,
  parameter int              I_ADDR_W   = 6,
  parameter int              D_ADDR_W   = 8,
  parameter int              RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0001
) (
  input  logic              mem_clk,
  input  logic              reset,
  mem_unit_param_if.slave   bus
);

  localparam int MAX_W   = (I_ADDR_W > D_ADDR_W) ? I_ADDR_W : D_ADDR_W;
  localparam int I_DEPTH = 1 << I_ADDR_W;
  localparam int D_DEPTH = 1 << D_ADDR_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [MAX_W-1:0]    clear_ptr_q, clear_ptr_d;
  logic [I_ADDR_W-1:0] load_ptr_q, load_ptr_d;

  logic [DATA_W-1:0] i_mem [I_DEPTH];
  logic [DATA_W-1:0] d_mem [D_DEPTH];

  logic in_clear, in_load, in_run;
  logic ld_fire, wr_fire, rd_fire;
  logic clear_last, load_last;
  logic clr_i_in, clr_d_in;

  assign in_clear   = (state_q == ST_CLEAR);
  assign in_load    = (state_q == ST_LOAD);
  assign in_run     = (state_q == ST_RUN);
  assign ld_fire    = in_load && bus.ld_valid;
  assign wr_fire    = in_run && bus.d_req && bus.d_rw;
  assign rd_fire    = in_run && bus.d_req && !bus.d_rw;
  assign clear_last = &clear_ptr_q;
  assign load_last  = &load_ptr_q;

  // The clear sweep covers the larger array; the smaller one only takes writes in its range.
  if (MAX_W > I_ADDR_W) begin : g_clr_i_part
    assign clr_i_in = ~|clear_ptr_q[MAX_W-1:I_ADDR_W];
  end else begin : g_clr_i_full
    assign clr_i_in = 1'b1;
  end

  if (MAX_W > D_ADDR_W) begin : g_clr_d_part
    assign clr_d_in = ~|clear_ptr_q[MAX_W-1:D_ADDR_W];
  end else begin : g_clr_d_full
    assign clr_d_in = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    load_ptr_d  = load_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_last) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_fire) begin
          if (!load_last) load_ptr_d = load_ptr_q + 1'b1;
          if (bus.ld_last || load_last) state_d = ST_RUN;
        end
      end
      ST_RUN: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      load_ptr_q  <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      load_ptr_q  <= load_ptr_d;
    end
  end

  logic                i_we, d_we;
  logic [I_ADDR_W-1:0] i_waddr;
  logic [D_ADDR_W-1:0] d_waddr;
  logic [DATA_W-1:0]   i_wdata, d_wdata;

  always_comb begin
    i_we    = 1'b0;
    i_waddr = load_ptr_q;
    i_wdata = bus.ld_data;
    if (in_clear) begin
      i_we    = clr_i_in;
      i_waddr = clear_ptr_q[I_ADDR_W-1:0];
      i_wdata = NOP_WORD;
    end else if (ld_fire) begin
      i_we    = 1'b1;
    end
  end

  always_comb begin
    d_we    = 1'b0;
    d_waddr = bus.d_addr;
    d_wdata = bus.dw_data;
    if (in_clear) begin
      d_we    = clr_d_in;
      d_waddr = clear_ptr_q[D_ADDR_W-1:0];
      d_wdata = '0;
    end else if (wr_fire) begin
      d_we    = 1'b1;
    end
  end

  // Arrays carry no reset; writes are simply held off while reset is asserted.
  always_ff @(posedge mem_clk) begin
    if (i_we && reset) i_mem[i_waddr] <= i_wdata;
    if (d_we && reset) d_mem[d_waddr] <= d_wdata;
  end

  logic              rd_v1_q;
  logic [DATA_W-1:0] rd_d1_q;

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= rd_fire;
      if (rd_fire) rd_d1_q <= d_mem[bus.d_addr];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign bus.dr       = rd_d1_q;
    assign bus.dr_valid = rd_v1_q;
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic              rd_v2_q;
    logic [DATA_W-1:0] rd_d2_q;
    always_ff @(posedge mem_clk or negedge reset) begin
      if (!reset) begin
        rd_v2_q <= 1'b0;
        rd_d2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) rd_d2_q <= rd_d1_q;
      end
    end
    assign bus.dr       = rd_d2_q;
    assign bus.dr_valid = rd_v2_q;
  end else begin : g_bad_latency
    $error("mem_unit_param: RD_LATENCY must be 1 or 2");
  end

  assign bus.d_ready   = in_run;
  assign bus.i_valid   = in_run;
  assign bus.init_done = in_run;
  assign bus.ld_ready  = in_load;
  assign bus.ir        = in_run ? i_mem[bus.i_addr] : NOP_WORD;

endmodule

// File: tb/tb_mem_unit_param.sv
// tb/tb_mem_unit_param.sv - scoreboard bench driving latency-1 and latency-2 instances in lockstep
module tb_mem_unit_param;

  localparam logic [15:0] NOP = 16'h0001;

  logic mem_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  mem_unit_param_if #(.DATA_W(16), .I_ADDR_W(6), .D_ADDR_W(8)) bus1 ();
  mem_unit_param_if #(.DATA_W(16), .I_ADDR_W(6), .D_ADDR_W(8)) bus2 ();

  mem_unit_param #(.DATA_W(16), .I_ADDR_W(6), .D_ADDR_W(8), .RD_LATENCY(1), .NOP_WORD(16'h0001))
    u_lat1 (.mem_clk(mem_clk), .reset(reset), .bus(bus1.slave));
  mem_unit_param #(.DATA_W(16), .I_ADDR_W(6), .D_ADDR_W(8), .RD_LATENCY(2), .NOP_WORD(16'h0001))
    u_lat2 (.mem_clk(mem_clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic drv_d(input logic req, input logic rw, input logic [7:0] a, input logic [15:0] d);
    bus1.d_req = req; bus1.d_rw = rw; bus1.d_addr = a; bus1.dw_data = d;
    bus2.d_req = req; bus2.d_rw = rw; bus2.d_addr = a; bus2.dw_data = d;
  endtask

  task automatic drv_ld(input logic v, input logic l, input logic [15:0] d);
    bus1.ld_valid = v; bus1.ld_last = l; bus1.ld_data = d;
    bus2.ld_valid = v; bus2.ld_last = l; bus2.ld_data = d;
  endtask

  task automatic set_iaddr(input logic [5:0] a);
    bus1.i_addr = a;
    bus2.i_addr = a;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    drv_d(1'b1, 1'b1, a, d);
    step();
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] expv);
    exp_t e;
    drv_d(1'b1, 1'b0, a, 16'h0000);
    e.data = expv; e.due = cyc + 1; q1.push_back(e);
    e.data = expv; e.due = cyc + 2; q2.push_back(e);
    step();
  endtask

  task automatic wait_clear(input string tag);
    int n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (bus1.ld_ready !== 1'b1 && n < 1000) begin
      if (bus1.d_ready !== 1'b0 || bus2.d_ready !== 1'b0 || bus1.ir !== NOP || bus2.ir !== NOP ||
          bus1.init_done !== 1'b0 || bus2.init_done !== 1'b0)
        bad = 1'b1;
      step();
      n++;
    end
    chk({tag, "_clear_cycles"}, 16'(n), 16'd256);
    chk({tag, "_clear_defaults"}, {15'd0, bad}, 16'd0);
    chk({tag, "_lat2_ld_ready"}, {15'd0, bus2.ld_ready}, 16'd1);
  endtask

  always @(negedge mem_clk) begin
    exp_t e1;
    exp_t e2;
    if (bus1.dr_valid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL lat1_unexpected_pulse: got dr=%h at cycle %0d expected no pulse", bus1.dr, cyc);
      end else begin
        e1 = q1.pop_front();
        if (bus1.dr !== e1.data || cyc != e1.due) begin
          errors++;
          $display("FAIL lat1_read: got %h at cycle %0d expected %h at cycle %0d", bus1.dr, cyc, e1.data, e1.due);
        end
      end
    end
    if (bus2.dr_valid === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL lat2_unexpected_pulse: got dr=%h at cycle %0d expected no pulse", bus2.dr, cyc);
      end else begin
        e2 = q2.pop_front();
        if (bus2.dr !== e2.data || cyc != e2.due) begin
          errors++;
          $display("FAIL lat2_read: got %h at cycle %0d expected %h at cycle %0d", bus2.dr, cyc, e2.data, e2.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] ir_tab [4];

  initial begin
    ir_tab[0] = 16'h1104; ir_tab[1] = 16'h1205; ir_tab[2] = 16'h2312; ir_tab[3] = 16'h0001;
    drv_d(1'b0, 1'b0, 8'h00, 16'h0000);
    drv_ld(1'b0, 1'b0, 16'h0000);
    set_iaddr(6'd0);
    reset = 1'b0;
    step();
    step();

    chk("rst_dr_valid1", {15'd0, bus1.dr_valid}, 16'd0);
    chk("rst_dr_valid2", {15'd0, bus2.dr_valid}, 16'd0);
    chk("rst_dr1", bus1.dr, 16'h0000);
    chk("rst_dr2", bus2.dr, 16'h0000);
    chk("rst_d_ready", {15'd0, bus1.d_ready}, 16'd0);
    chk("rst_ld_ready", {15'd0, bus1.ld_ready}, 16'd0);
    chk("rst_i_valid", {15'd0, bus1.i_valid}, 16'd0);
    chk("rst_init_done", {15'd0, bus2.init_done}, 16'd0);
    chk("rst_ir", bus1.ir, NOP);

    reset = 1'b1;
    wait_clear("a");

    // Data requests while not in RUN must be dropped
    wr(8'h20, 16'hDEAD);
    drv_d(1'b1, 1'b0, 8'h20, 16'h0000);
    step();
    drv_d(1'b0, 1'b0, 8'h00, 16'h0000);

    drv_ld(1'b1, 1'b0, 16'h1104); step();
    drv_ld(1'b0, 1'b0, 16'h0000); step(); step();
    drv_ld(1'b1, 1'b0, 16'h1205); step();
    drv_ld(1'b0, 1'b0, 16'h0000); step();
    drv_ld(1'b1, 1'b1, 16'h2312);
    chk("pre_last_init_done", {15'd0, bus1.init_done}, 16'd0);
    step();
    drv_ld(1'b0, 1'b0, 16'h0000);
    chk("init_done1", {15'd0, bus1.init_done}, 16'd1);
    chk("init_done2", {15'd0, bus2.init_done}, 16'd1);
    chk("run_ld_ready", {15'd0, bus1.ld_ready}, 16'd0);
    chk("run_i_valid", {15'd0, bus2.i_valid}, 16'd1);
    chk("run_d_ready", {15'd0, bus1.d_ready}, 16'd1);

    for (int i = 0; i < 4; i++) begin
      set_iaddr(6'(i));
      #1;
      chk($sformatf("ir1_addr%0d", i), bus1.ir, ir_tab[i]);
      chk($sformatf("ir2_addr%0d", i), bus2.ir, ir_tab[i]);
    end

    wr(8'h10, 16'hBEEF);
    rd(8'h10, 16'hBEEF);
    rd(8'h11, 16'h0000);
    rd(8'h20, 16'h0000);
    rd(8'h10, 16'hBEEF);
    drv_d(1'b0, 1'b0, 8'h00, 16'h0000);
    step(); step(); step();
    chk("dr_hold1", bus1.dr, 16'hBEEF);
    chk("dr_hold2", bus2.dr, 16'hBEEF);

    wr(8'h01, 16'h0001);
    wr(8'h02, 16'h0002);
    wr(8'h03, 16'h0003);
    rd(8'h01, 16'h0001);
    rd(8'h02, 16'h0002);
    rd(8'h03, 16'h0003);
    drv_d(1'b0, 1'b0, 8'h00, 16'h0000);
    step(); step(); step(); step();

    // Abort an in-flight read with reset; neither instance may pulse afterwards
    drv_d(1'b1, 1'b0, 8'h03, 16'h0000);
    step();
    drv_d(1'b0, 1'b0, 8'h00, 16'h0000);
    reset = 1'b0;
    #1;
    chk("abort_dr_valid1", {15'd0, bus1.dr_valid}, 16'd0);
    chk("abort_dr_valid2", {15'd0, bus2.dr_valid}, 16'd0);
    chk("abort_dr2", bus2.dr, 16'h0000);
    chk("abort_ir", bus2.ir, NOP);
    step(); step();
    reset = 1'b1;
    wait_clear("b");

    drv_ld(1'b1, 1'b0, 16'h7777); step();
    drv_ld(1'b1, 1'b0, 16'h7778);
    reset = 1'b0;
    #1;
    chk("load_abort_ld_ready", {15'd0, bus1.ld_ready}, 16'd0);
    step();
    drv_ld(1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    wait_clear("c");

    for (int i = 0; i < 64; i++) begin
      drv_ld(1'b1, 1'b0, 16'(16'h4000 + i));
      if (i == 63) chk("init_before_64th", {15'd0, bus1.init_done}, 16'd0);
      step();
    end
    chk("init_after_64th1", {15'd0, bus1.init_done}, 16'd1);
    chk("init_after_64th2", {15'd0, bus2.init_done}, 16'd1);
    drv_ld(1'b1, 1'b0, 16'hFFFF);
    step(); step();
    drv_ld(1'b0, 1'b0, 16'h0000);
    chk("extra_ld_ready", {15'd0, bus1.ld_ready}, 16'd0);
    set_iaddr(6'd0);  #1; chk("ir_full_0", bus1.ir, 16'h4000);
    set_iaddr(6'd1);  #1; chk("ir_full_1", bus2.ir, 16'h4001);
    set_iaddr(6'd63); #1; chk("ir_full_63", bus1.ir, 16'h403F);

    rd(8'h10, 16'h0000);
    rd(8'h01, 16'h0000);
    drv_d(1'b0, 1'b0, 8'h00, 16'h0000);
    step(); step(); step(); step();

    chk("queues_drained", 16'(q1.size() + q2.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_unit_param.md
Name: mem_unit_param

Overview:
- Parametrised successor to the CPU's combined instruction/data memory.
- Holds separate instruction and data arrays, clocked by mem_clk.
- After reset it runs a hardware clear sequence, then a streamed instruction-load phase, then normal run mode.
- Run mode provides a combinational instruction fetch and a pipelined data port with a req/ready handshake and read-valid.

Parameters:
DATA_W, 16, word width of both arrays
I_ADDR_W, 6, instruction address width; instruction depth = 2^I_ADDR_W
D_ADDR_W, 8, data address width; data depth = 2^D_ADDR_W
RD_LATENCY, 1, data read latency in cycles; legal values 1 or 2
NOP_WORD, 16'h0001, fill value for instruction memory and fetch value while not in run mode

Ports:
mem_clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
i_addr  in  I_ADDR_W  instruction fetch address
ir  out  DATA_W  fetched instruction
i_valid  out  1  high only in RUN
d_req  in  1  data access request
d_rw  in  1  1 = write, 0 = read
d_addr  in  D_ADDR_W  data address
dw_data  in  DATA_W  write data
d_ready  out  1  data port can accept a request
dr  out  DATA_W  read data
dr_valid  out  1  one-cycle pulse marking dr as new read data
ld_valid  in  1  load word valid
ld_data  in  DATA_W  instruction word to load
ld_last  in  1  current load word is the final one
ld_ready  out  1  high only in LOAD
init_done  out  1  high only in RUN

Behaviour:
- Reset (reset=0, async):
  - State goes to CLEAR; clear_ptr=0, load_ptr=0.
  - Read pipeline is flushed.
  - Output values during reset: dr=0, dr_valid=0, d_ready=0, ld_ready=0, i_valid=0, init_done=0, ir=NOP_WORD.
  - Array contents are not reset asynchronously.
- State CLEAR:
  - Each cycle writes d_mem[clear_ptr]=0 (if clear_ptr < data depth) and i_mem[clear_ptr]=NOP_WORD (if clear_ptr < instruction depth), then increments clear_ptr.
  - Lasts exactly 2^max(I_ADDR_W,D_ADDR_W) cycles, then moves to LOAD.
- State LOAD:
  - ld_ready=1. A transfer occurs when ld_valid && ld_ready; it writes i_mem[load_ptr]=ld_data and increments load_ptr.
  - Moves to RUN on the edge of the transfer that has ld_last=1, or of the transfer with load_ptr = depth-1, whichever comes first.
  - Words not loaded keep NOP_WORD.
  - ld_valid=0 holds LOAD indefinitely.
- State RUN:
  - Terminal until reset. init_done=1, i_valid=1, ld_ready=0.
  - ld_* inputs are ignored.
- Instruction fetch: ir = i_mem[i_addr] combinationally in RUN; ir = NOP_WORD in every other state.
- Data port:
  - d_ready=1 only in RUN. Requests with d_ready=0 are dropped, not queued.
  - Write: when d_req && d_ready && d_rw, d_mem[d_addr] <= dw_data on that edge. No dr_valid pulse.
  - Read: when d_req && d_ready && !d_rw, the address is captured.
    - RD_LATENCY=1: dr and dr_valid update on the next edge.
    - RD_LATENCY=2: one extra register stage.
  - Back-to-back reads are accepted every cycle (fully pipelined, throughput 1/cycle).
  - dr holds its last value between pulses.
  - Read-after-write: a read accepted the cycle after a write to the same address returns the new data. Memory write plus a registered read satisfies this; no bypass is needed.
- Widths: all addresses are full-range, with no wrap beyond depth.
  - load_ptr saturates at depth-1 through the RUN transition.
  - clear_ptr is wide enough for max depth.
- Reset mid-operation: any state or in-flight read is aborted. dr_valid is forced to 0 immediately and no stale pulse follows deassertion.
- Illegal RD_LATENCY: elaboration-time error.

Test Plan:
- Reset release, defaults: count cycles until ld_ready=1 -> exactly 256 cycles; d_ready=0, ir=16'h0001 throughout.
- Load 3 words 16'h1104, 16'h1205, 16'h2312, with ld_last on the third and ld_valid gaps between words -> init_done rises after the third transfer. ir at i_addr 0,1,2 = those words; ir at i_addr 3 = 16'h0001.
- RUN: write 16'hBEEF to d_addr 8'h10, then read 8'h10 the next cycle -> dr=16'hBEEF with dr_valid one cycle after the read is accepted. Read 8'h11 -> 16'h0000.
- RD_LATENCY=2: reads to 8'h01, 8'h02, 8'h03 on consecutive cycles (pre-written 1,2,3) -> dr_valid high on 3 consecutive cycles, starting 2 cycles after the first read, with data 1,2,3 in order.
- 64 loads with no ld_last -> RUN after the 64th transfer; a 65th ld_valid is ignored and i_mem[0] is unchanged.
- Assert reset during an in-flight RD_LATENCY=2 read and during LOAD -> dr_valid=0 immediately, no pulse after release, state restarts in CLEAR, and d_mem[8'h10] reads 0 after the new clear.
